// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register word
// offsets, STATUS bit positions and serializer states. Honours UART_TX_PARITY_EN.
package mmio_pkg;

    // Word offsets, i.e. adr[3:2]; offset 2'b11 is unmapped
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;

    localparam int unsigned STAT_BUSY      = 0;
    localparam int unsigned STAT_EMPTY     = 1;
    localparam int unsigned STAT_FULL      = 2;
    localparam int unsigned STAT_OVF       = 3;
    localparam int unsigned STAT_COUNT_LSB = 4;
    localparam int unsigned STAT_COUNT_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_t;

    // A bit time shorter than two clocks is not supported by the serializer
    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < 16'd2) ? 16'd2 : v;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO with occupancy count; a push to a full FIFO is accepted
// only when a pop happens in the same cycle.
module byte_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/DIVISOR window, byte FIFO and
// 8N1 serializer. Define UART_TX_PARITY_EN to insert an even-parity bit.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] adr,
    input  logic [31:0] writedata,
    input  logic        memwrite,
    output logic        io_hit,
    output logic [31:0] io_readdata,
    output logic        txd,
    output logic        tx_busy
);

    import mmio_pkg::*;

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] DIV_RST = 16'(CLKS_PER_BIT);

    logic [1:0]    reg_sel;
    logic          wr_txdata, wr_status, wr_div;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_rd_data;
    logic [31:0]   status_word;
    logic          bit_end, load;
    logic          unused_bits;

    logic [15:0] div_q, div_d;
    logic        ovf_q, ovf_d;
    tx_state_t   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_lat_q, div_lat_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    assign reg_sel     = adr[3:2];
    assign io_hit      = (adr[31:4] == BASE_ADDR[31:4]) && (reg_sel != 2'b11);
    assign wr_txdata   = memwrite & io_hit & (reg_sel == REG_TXDATA);
    assign wr_status   = memwrite & io_hit & (reg_sel == REG_STATUS);
    assign wr_div      = memwrite & io_hit & (reg_sel == REG_DIVISOR);
    assign unused_bits = ^{adr[1:0], writedata[31:16]};

    byte_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push    (wr_txdata),
        .pop     (fifo_pop),
        .wr_data (writedata[7:0]),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign tx_busy = (state_q != ST_IDLE) | ~fifo_empty;
    assign txd     = txd_q;

    always_comb begin
        status_word                                   = '0;
        status_word[STAT_BUSY]                        = tx_busy;
        status_word[STAT_EMPTY]                       = fifo_empty;
        status_word[STAT_FULL]                        = fifo_full;
        status_word[STAT_OVF]                         = ovf_q;
        status_word[STAT_COUNT_LSB +: STAT_COUNT_W]   = 4'(fifo_count);
        io_readdata = '0;
        if (io_hit) begin
            case (reg_sel)
                REG_STATUS:  io_readdata = status_word;
                REG_DIVISOR: io_readdata = {16'b0, div_q};
                default:     io_readdata = '0;
            endcase
        end
    end

    always_comb begin
        div_d = div_q;
        if (wr_div) begin
            div_d = clamp_div(writedata[15:0]);
        end
        ovf_d = ovf_q;
        if (wr_status) begin
            ovf_d = 1'b0;
        end
        if (wr_txdata && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end
    end

    assign bit_end = (cnt_q == div_lat_q - 16'd1);

    // txd is registered from the next state so each bit lasts exactly div_lat_q clocks
    always_comb begin
        state_d   = state_q;
        div_lat_d = div_lat_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        txd_d     = txd_q;
        cnt_d     = (state_q == ST_IDLE || bit_end) ? 16'd0 : cnt_q + 16'd1;
        fifo_pop  = 1'b0;
        load      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                    txd_d     = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        txd_d   = parity_q;
`else
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase
        if (load) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_rd_data;
            div_lat_d = div_q;
            cnt_d     = 16'd0;
            state_d   = ST_START;
            txd_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d  = ^fifo_rd_data;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q     <= DIV_RST;
            ovf_q     <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            div_lat_q <= DIV_RST;
            shift_q   <= '0;
            bit_idx_q <= '0;
            txd_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            div_q     <= div_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_lat_q <= div_lat_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            txd_q     <= txd_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register decode, frame timing, FIFO overflow,
// divisor latching, back-to-back frames and reset behaviour.
module tb_uart_tx_mmio;

    localparam logic [31:0] A_TX  = 32'hFFFF_0000;
    localparam logic [31:0] A_ST  = 32'hFFFF_0004;
    localparam logic [31:0] A_DIV = 32'hFFFF_0008;
    localparam logic [31:0] A_UNM = 32'hFFFF_000C;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] adr;
    logic [31:0] writedata;
    logic        memwrite;
    logic        io_hit;
    logic [31:0] io_readdata;
    logic        txd;
    logic        tx_busy;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    uart_tx_mmio #(
        .BASE_ADDR    (32'hFFFF_0000),
        .CLKS_PER_BIT (16),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .adr         (adr),
        .writedata   (writedata),
        .memwrite    (memwrite),
        .io_hit      (io_hit),
        .io_readdata (io_readdata),
        .txd         (txd),
        .tx_busy     (tx_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        adr       = a;
        writedata = d;
        memwrite  = 1'b1;
        @(posedge clk);
        #1;
        memwrite  = 1'b0;
        adr       = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        adr = a;
        #1;
        d   = io_readdata;
    endtask

    // Called one step after the edge on which txd fell; returns one step after the frame's last edge
    task automatic check_frame(input logic [7:0] data, input int unsigned div, input string tag);
        logic [10:0] bits;
        int unsigned nbits;
        int unsigned ones;
        int unsigned busy_lo;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = data;
`ifdef UART_TX_PARITY_EN
        bits[9]   = ^data;
        nbits     = 11;
`else
        nbits     = 10;
`endif
        busy_lo = 0;
        for (int unsigned b = 0; b < nbits; b++) begin
            ones = 0;
            for (int unsigned c = 0; c < div; c++) begin
                if (txd === 1'b1) ones++;
                if (tx_busy !== 1'b1) busy_lo++;
                @(posedge clk);
                #1;
            end
            chk($sformatf("%s_bit%0d_high_cycles", tag, b), ones, bits[b] ? div : 0);
        end
        chk($sformatf("%s_busy_low_cycles", tag), busy_lo, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic [7:0]  b;

        reset     = 1'b1;
        memwrite  = 1'b0;
        adr       = '0;
        writedata = '0;
        tick(3);
        chk("txd_in_reset", txd, 1);
        reset = 1'b0;
        tick(1);

        // reset state and decode
        chk("rst_txd", txd, 1);
        chk("rst_busy", tx_busy, 0);
        rd(A_ST, r);  chk("rst_status", r, 32'h0000_0002);
        rd(A_DIV, r); chk("rst_divisor", r, 32'd16);
        rd(A_TX, r);  chk("txdata_read_zero", r, 0);
        chk("hit_txdata", io_hit, 1);
        rd(A_UNM, r); chk("unmapped_read", r, 0);
        chk("unmapped_hit", io_hit, 0);
        rd(32'hFFFE_0004, r); chk("other_window_hit", io_hit, 0);

        // divisor clamp and field extraction
        sw(A_DIV, 32'd1);          rd(A_DIV, r); chk("div_clamp_1", r, 2);
        sw(A_DIV, 32'd0);          rd(A_DIV, r); chk("div_clamp_0", r, 2);
        sw(A_DIV, 32'hABCD_0003);  rd(A_DIV, r); chk("div_low16", r, 3);
        sw(A_DIV, 32'd16);

        // writes outside the window or to the unmapped slot must not push
        sw(32'hFFFE_0000, 32'h12);
        sw(A_UNM, 32'h12);
        rd(A_ST, r); chk("no_push_status", r, 32'h0000_0002);
        chk("no_push_busy", tx_busy, 0);

        // single frame 0x55 at divisor 16
        sw(A_TX, 32'h55);
        chk("pre_start_txd", txd, 1);
        chk("pre_start_busy", tx_busy, 1);
        rd(A_ST, r); chk("queued_status", r, 32'h0000_0011);
        tick(1);
        chk("start_latency_txd", txd, 0);
        check_frame(8'h55, 16, "f55");
        chk("f55_idle_busy", tx_busy, 0);
        chk("f55_idle_txd", txd, 1);

        // divisor change mid-frame plus a queued byte: no gap, new divisor on next frame
        sw(A_TX, 32'hA3);
        tick(1);
        chk("fA3_start", txd, 0);
        fork
            check_frame(8'hA3, 16, "fA3");
            begin
                tick(40);
                sw(A_DIV, 32'd8);
                sw(A_TX, 32'h3C);
                rd(A_DIV, r); chk("div_mid_frame_read", r, 8);
            end
        join
        check_frame(8'h3C, 8, "f3C");
        chk("f3C_idle_busy", tx_busy, 0);

        // overflow: serializer busy, five pushes into a depth-4 FIFO
        sw(A_TX, 32'h11);
        tick(1);
        chk("f11_start", txd, 0);
        fork
            check_frame(8'h11, 8, "f11");
            begin
                for (int unsigned i = 0; i < 5; i++) begin
                    b = 8'hB0 + 8'(i);
                    sw(A_TX, {24'b0, b});
                end
                rd(A_ST, r); chk("ovf_status", r, 32'h0000_004D);
                sw(A_ST, 32'hFFFF_FFFF);
                rd(A_ST, r); chk("ovf_cleared_status", r, 32'h0000_0045);
            end
        join
        for (int unsigned i = 0; i < 4; i++) begin
            b = 8'hB0 + 8'(i);
            check_frame(b, 8, $sformatf("fB%0d", i));
        end
        chk("drain_busy", tx_busy, 0);
        rd(A_ST, r); chk("drain_status", r, 32'h0000_0002);

        // asynchronous reset in the middle of DATA
        sw(A_DIV, 32'd5);
        sw(A_TX, 32'h00);
        sw(A_TX, 32'hFF);
        tick(12);
        chk("mid_data_txd", txd, 0);
        rd(A_ST, r); chk("mid_data_status", r, 32'h0000_0011);
        reset = 1'b1;
        #1;
        chk("async_rst_txd", txd, 1);
        chk("async_rst_busy", tx_busy, 0);
        tick(1);
        reset = 1'b0;
        rd(A_ST, r);  chk("post_rst_status", r, 32'h0000_0002);
        rd(A_DIV, r); chk("post_rst_divisor", r, 16);
        tick(20);
        chk("post_rst_idle_txd", txd, 1);
        chk("post_rst_idle_busy", tx_busy, 0);

        // push that coincides with a reset edge is discarded
        reset = 1'b1;
        sw(A_TX, 32'h5A);
        reset = 1'b0;
        rd(A_ST, r); chk("rst_push_status", r, 32'h0000_0002);
        tick(3);
        chk("rst_push_txd", txd, 1);
        chk("rst_push_busy", tx_busy, 0);

`ifdef UART_TX_PARITY_EN
        // 0x07 has three ones, so the even-parity bit is 1
        sw(A_TX, 32'h07);
        tick(1);
        chk("f07_start", txd, 0);
        check_frame(8'h07, 16, "f07");
        chk("f07_idle_busy", tx_busy, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
